// File: rtl/mod_updown_counter_pkg.sv
// Shared constants, control payload type and parameter legality check for the
// modulo up/down counter.
package mod_updown_counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam bit   MODE_WRAP = 1'b0;
    localparam bit   MODE_SAT  = 1'b1;

    localparam int unsigned WIDTH_MIN  = 2;
    localparam int unsigned WIDTH_MAX  = 32;
    localparam int unsigned MODULO_MIN = 2;

    // Per-edge control inputs, gathered so the priority mux reads as one payload.
    typedef struct packed {
        logic clear;
        logic load;
        logic enable;
        logic up_dn;
    } ctrl_t;

    function automatic bit params_legal(
        input int unsigned     width,
        input longint unsigned modulo,
        input longint unsigned reset_val
    );
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
               (modulo >= 64'(MODULO_MIN)) && (modulo <= (64'd1 << width)) &&
               (reset_val < modulo);
    endfunction

endpackage

// File: rtl/mod_updown_counter_addsub.sv
// Combinational +/-1 unit: wrapped next value and range-end detect for the
// current direction.
module mod_updown_counter_addsub
    import mod_updown_counter_pkg::*;
#(
    parameter int unsigned     WIDTH  = 4,
    parameter longint unsigned MODULO = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_c,
    output logic             at_limit_c
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;

    logic is_max_c;
    logic is_zero_c;

    assign is_max_c  = (count == MAX_VAL);
    assign is_zero_c = (count == ZERO_VAL);

    always_comb begin
        at_limit_c = ((up_dn == DIR_UP) && is_max_c) ||
                     ((up_dn == DIR_DOWN) && is_zero_c);
        next_c     = count;
        // Wrapping at the range ends keeps every produced value below MODULO.
        if (up_dn == DIR_UP) begin
            next_c = is_max_c ? ZERO_VAL : count + WIDTH'(1);
        end else begin
            next_c = is_zero_c ? MAX_VAL : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// WIDTH-bit modulo-N up/down counter with clear, clamped load, wrap/saturate
// mode, terminal-count decode and a registered wrap pulse.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULO    = 16,
    parameter bit              SATURATE  = 1'b0,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    if (!params_legal(WIDTH, MODULO, RESET_VAL)) begin : g_bad_params
        $error("mod_updown_counter: illegal WIDTH/MODULO/RESET_VAL combination");
    end

    ctrl_t            ctrl_c;
    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_d, wrap_q;
    logic [WIDTH-1:0] next_c;
    logic             at_limit_c;
    logic             load_in_range_c;

    assign ctrl_c = '{clear: clear, load: load, enable: enable, up_dn: up_dn};

    mod_updown_counter_addsub #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) u_addsub (
        .count      (count_q),
        .up_dn      (ctrl_c.up_dn),
        .next_c     (next_c),
        .at_limit_c (at_limit_c)
    );

    // Compare at WIDTH+1 bits so MODULO = 2^WIDTH never truncates to zero.
    assign load_in_range_c = ({1'b0, load_val} < MOD_EXT);

    // Priority: clear > load > enable > hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (ctrl_c.clear) begin
            count_d = RST_VAL;
        end else if (ctrl_c.load) begin
            count_d = load_in_range_c ? load_val : MAX_VAL;
        end else if (ctrl_c.enable) begin
            if (!(at_limit_c && (SATURATE != MODE_WRAP))) begin
                count_d = next_c;
                wrap_d  = at_limit_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RST_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = at_limit_c;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: four instances cover wrap, saturate,
// full binary range and the MODULO=2 corner.
module tb_mod_updown_counter;

    logic clk;
    logic reset;

    // a: WIDTH=4 MODULO=10 wrap RESET_VAL=3
    logic       a_en, a_clr, a_ld, a_ud;
    logic [3:0] a_lv, a_cnt;
    logic       a_tc, a_wrap;
    // s: WIDTH=4 MODULO=10 saturate RESET_VAL=0
    logic       s_en, s_clr, s_ld, s_ud;
    logic [3:0] s_lv, s_cnt;
    logic       s_tc, s_wrap;
    // f: WIDTH=4 MODULO=16 wrap RESET_VAL=0
    logic       f_en, f_clr, f_ld, f_ud;
    logic [3:0] f_lv, f_cnt;
    logic       f_tc, f_wrap;
    // m: WIDTH=2 MODULO=2 wrap RESET_VAL=0
    logic       m_en, m_clr, m_ld, m_ud;
    logic [1:0] m_lv, m_cnt;
    logic       m_tc, m_wrap;

    int checks = 0;
    int errors = 0;

    mod_updown_counter #(.WIDTH(4), .MODULO(64'd10), .SATURATE(1'b0), .RESET_VAL(64'd3)) dut_a (
        .clk(clk), .reset(reset), .enable(a_en), .clear(a_clr), .load(a_ld),
        .load_val(a_lv), .up_dn(a_ud), .count(a_cnt), .tc(a_tc), .wrap(a_wrap));

    mod_updown_counter #(.WIDTH(4), .MODULO(64'd10), .SATURATE(1'b1), .RESET_VAL(64'd0)) dut_s (
        .clk(clk), .reset(reset), .enable(s_en), .clear(s_clr), .load(s_ld),
        .load_val(s_lv), .up_dn(s_ud), .count(s_cnt), .tc(s_tc), .wrap(s_wrap));

    mod_updown_counter #(.WIDTH(4), .MODULO(64'd16), .SATURATE(1'b0), .RESET_VAL(64'd0)) dut_f (
        .clk(clk), .reset(reset), .enable(f_en), .clear(f_clr), .load(f_ld),
        .load_val(f_lv), .up_dn(f_ud), .count(f_cnt), .tc(f_tc), .wrap(f_wrap));

    mod_updown_counter #(.WIDTH(2), .MODULO(64'd2), .SATURATE(1'b0), .RESET_VAL(64'd0)) dut_m (
        .clk(clk), .reset(reset), .enable(m_en), .clear(m_clr), .load(m_ld),
        .load_val(m_lv), .up_dn(m_ud), .count(m_cnt), .tc(m_tc), .wrap(m_wrap));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (a_cnt !== 4'd3) begin errors++; $display("FAIL reset_count: got %0d want 3", a_cnt); end
        checks++;
        if (a_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", a_wrap); end
        checks++;
        if (s_cnt !== 4'd0) begin errors++; $display("FAIL reset_count_s: got %0d want 0", s_cnt); end
        reset = 1'b1;
        a_ld = 1'b1; a_lv = 4'd7;
        step();
        a_ld = 1'b0;
        checks++;
        if (a_cnt !== 4'd7) begin errors++; $display("FAIL pre_reset_load: got %0d want 7", a_cnt); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (a_cnt !== 4'd3) begin errors++; $display("FAIL async_reset: got %0d want 3", a_cnt); end
        checks++;
        if (a_wrap !== 1'b0) begin errors++; $display("FAIL async_reset_wrap: got %b want 0", a_wrap); end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_up_wrap();
        int exp;
        a_ld = 1'b1; a_lv = 4'd0;
        step();
        a_ld = 1'b0;
        checks++;
        if (a_cnt !== 4'd0) begin errors++; $display("FAIL up_start: got %0d want 0", a_cnt); end
        a_en = 1'b1; a_ud = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = i % 10;
            checks++;
            if (a_cnt !== 4'(exp)) begin errors++; $display("FAIL up_count step %0d: got %0d want %0d", i, a_cnt, exp); end
            checks++;
            if (a_wrap !== (exp == 0)) begin errors++; $display("FAIL up_wrap step %0d: got %b want %b", i, a_wrap, exp == 0); end
            checks++;
            if (a_tc !== (exp == 9)) begin errors++; $display("FAIL up_tc step %0d: got %b want %b", i, a_tc, exp == 9); end
        end
        a_en = 1'b0;
    endtask

    task automatic test_down_flip();
        int exp_cnt [3] = '{1, 0, 9};
        a_ld = 1'b1; a_lv = 4'd2;
        step();
        a_ld = 1'b0;
        a_en = 1'b1; a_ud = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (a_cnt !== 4'(exp_cnt[i])) begin errors++; $display("FAIL down_count step %0d: got %0d want %0d", i, a_cnt, exp_cnt[i]); end
            checks++;
            if (a_wrap !== (i == 2)) begin errors++; $display("FAIL down_wrap step %0d: got %b want %b", i, a_wrap, i == 2); end
            checks++;
            if (a_tc !== (exp_cnt[i] == 0)) begin errors++; $display("FAIL down_tc step %0d: got %b want %b", i, a_tc, exp_cnt[i] == 0); end
        end
        a_en = 1'b0;
        a_ud = 1'b1;
        #1;
        checks++;
        if (a_tc !== 1'b1) begin errors++; $display("FAIL flip_tc_up: got %b want 1", a_tc); end
        a_ud = 1'b0;
        #1;
        checks++;
        if (a_tc !== 1'b0) begin errors++; $display("FAIL flip_tc_down: got %b want 0", a_tc); end
        a_ud = 1'b1; a_en = 1'b1;
        step();
        a_en = 1'b0;
        checks++;
        if (a_cnt !== 4'd0) begin errors++; $display("FAIL flip_count: got %0d want 0", a_cnt); end
        checks++;
        if (a_wrap !== 1'b1) begin errors++; $display("FAIL flip_wrap: got %b want 1", a_wrap); end
    endtask

    task automatic test_load();
        a_en = 1'b0; a_ld = 1'b1; a_lv = 4'd7;
        step();
        checks++;
        if (a_cnt !== 4'd7) begin errors++; $display("FAIL load_7: got %0d want 7", a_cnt); end
        checks++;
        if (a_wrap !== 1'b0) begin errors++; $display("FAIL load_wrap: got %b want 0", a_wrap); end
        a_lv = 4'd12;
        step();
        checks++;
        if (a_cnt !== 4'd9) begin errors++; $display("FAIL load_clamp: got %0d want 9", a_cnt); end
        a_lv = 4'd5; a_clr = 1'b1; a_en = 1'b1;
        step();
        checks++;
        if (a_cnt !== 4'd3) begin errors++; $display("FAIL clear_over_load: got %0d want 3", a_cnt); end
        a_ld = 1'b0; a_clr = 1'b0; a_en = 1'b0;
    endtask

    task automatic test_saturate();
        int exp_dn [2] = '{0, 0};
        s_ld = 1'b1; s_lv = 4'd8;
        step();
        s_ld = 1'b0; s_en = 1'b1; s_ud = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (s_cnt !== 4'd9) begin errors++; $display("FAIL sat_up step %0d: got %0d want 9", i, s_cnt); end
            checks++;
            if (s_wrap !== 1'b0) begin errors++; $display("FAIL sat_up_wrap step %0d: got %b want 0", i, s_wrap); end
            checks++;
            if (s_tc !== 1'b1) begin errors++; $display("FAIL sat_up_tc step %0d: got %b want 1", i, s_tc); end
        end
        s_en = 1'b0; s_ld = 1'b1; s_lv = 4'd1;
        step();
        s_ld = 1'b0; s_en = 1'b1; s_ud = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (s_cnt !== 4'(exp_dn[i])) begin errors++; $display("FAIL sat_dn step %0d: got %0d want %0d", i, s_cnt, exp_dn[i]); end
            checks++;
            if (s_wrap !== 1'b0) begin errors++; $display("FAIL sat_dn_wrap step %0d: got %b want 0", i, s_wrap); end
            checks++;
            if (s_tc !== 1'b1) begin errors++; $display("FAIL sat_dn_tc step %0d: got %b want 1", i, s_tc); end
        end
        s_en = 1'b0;
    endtask

    task automatic test_full_range();
        int  exp_cnt;
        bit  exp_wrap;
        bit  en, clr, ld, ud;
        int  lv;
        f_ld = 1'b1; f_lv = 4'd15;
        step();
        f_ld = 1'b0; f_en = 1'b1; f_ud = 1'b1;
        step();
        checks++;
        if (f_cnt !== 4'd0) begin errors++; $display("FAIL full_wrap_count: got %0d want 0", f_cnt); end
        checks++;
        if (f_wrap !== 1'b1) begin errors++; $display("FAIL full_wrap_pulse: got %b want 1", f_wrap); end
        exp_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            en  = ($urandom_range(3) != 0);
            clr = ($urandom_range(9) == 0);
            ld  = ($urandom_range(5) == 0);
            ud  = 1'($urandom_range(1));
            lv  = int'($urandom_range(15));
            f_en = en; f_clr = clr; f_ld = ld; f_ud = ud; f_lv = 4'(lv);
            step();
            exp_wrap = 1'b0;
            if (clr) begin
                exp_cnt = 0;
            end else if (ld) begin
                exp_cnt = lv;
            end else if (en && ud) begin
                exp_wrap = (exp_cnt == 15);
                exp_cnt  = (exp_cnt + 1) % 16;
            end else if (en) begin
                exp_wrap = (exp_cnt == 0);
                exp_cnt  = (exp_cnt == 0) ? 15 : exp_cnt - 1;
            end
            checks++;
            if (f_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL rand_count cycle %0d: got %0d want %0d", i, f_cnt, exp_cnt); end
            checks++;
            if (f_wrap !== exp_wrap) begin errors++; $display("FAIL rand_wrap cycle %0d: got %b want %b", i, f_wrap, exp_wrap); end
            checks++;
            if (f_tc !== (ud ? (exp_cnt == 15) : (exp_cnt == 0))) begin
                errors++; $display("FAIL rand_tc cycle %0d: got %b count %0d up_dn %b", i, f_tc, exp_cnt, ud);
            end
        end
        f_en = 1'b0; f_clr = 1'b0; f_ld = 1'b0;
    endtask

    task automatic test_back_to_back();
        int exp;
        m_clr = 1'b1;
        step();
        m_clr = 1'b0; m_en = 1'b1; m_ud = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp = i % 2;
            checks++;
            if (m_cnt !== 2'(exp)) begin errors++; $display("FAIL mod2_count step %0d: got %0d want %0d", i, m_cnt, exp); end
            checks++;
            if (m_wrap !== (exp == 0)) begin errors++; $display("FAIL mod2_wrap step %0d: got %b want %b", i, m_wrap, exp == 0); end
        end
        m_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {a_en, a_clr, a_ld, a_ud} = '0; a_lv = '0;
        {s_en, s_clr, s_ld, s_ud} = '0; s_lv = '0;
        {f_en, f_clr, f_ld, f_ud} = '0; f_lv = '0;
        {m_en, m_clr, m_ld, m_ud} = '0; m_lv = '0;
        test_reset();
        test_up_wrap();
        test_down_flip();
        test_load();
        test_saturate();
        test_full_range();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
